instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the immediate generator and decoder.
- Owns the program counter and issues requests to instruction memory over a req/ack handshake.
- Latches the returned word into the instruction register that drives the immediate generator's 32-bit instruction input.
- Takes a branch redirect whose 12-bit offset is the immediate generator's output.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, instruction register value while empty (addi x0,x0,0).
- TIMEOUT_CYCLES, 16, cycles to wait for imem_ack before retry; used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  memory response valid; imem_rdata is sampled when high.
- imem_rdata  in  32  fetched instruction word.
- instruction  out  32  instruction register; feeds the immediate generator and decoder.
- pc_out  out  32  address of the word held in instruction.
- instr_valid  out  1  instruction/pc_out hold a valid fetched word.
- decode_ready  in  1  downstream consumes the word this cycle.
- branch_taken  in  1  redirect request for the instruction currently in decode.
- branch_offset  in  12  branch immediate in halfwords, two's complement.
- misaligned  out  1  sticky flag: redirect target not word-aligned.

Behaviour:
- Reset (synchronous, any state), next edge:
  - pc=RESET_PC, state=IDLE, imem_req=0.
  - instruction=NOP_INSTR, pc_out=RESET_PC, instr_valid=0, misaligned=0.
- States: IDLE, FETCH, VALID, HALT. Outputs are registered or decoded from state; no combinational path from imem_ack to imem_req.
- IDLE:
  - imem_req=0.
  - Unconditionally go to FETCH next cycle.
  - Any imem_ack seen in IDLE is ignored; this covers a stale response after reset mid-fetch.
- FETCH:
  - imem_req=1, imem_addr=pc, both held stable until ack.
  - An ack is legal in the same cycle req first rises.
  - On imem_ack: instruction<=imem_rdata, pc_out<=pc, pc<=pc+4 (mod 2^32, wraps from 32'hFFFFFFFC to 0), instr_valid<=1, state<=VALID.
  - Latency: ack at edge N gives instr_valid=1 after edge N.
- VALID:
  - imem_req=0, instr_valid=1; instruction and pc_out held stable.
  - Priority 1, branch_taken=1:
    - target = pc_out + sign_extend({branch_offset,1'b0}) to 32 bits, mod 2^32.
    - instr_valid<=0 and instruction<=NOP_INSTR.
    - If target[1:0]==0: pc<=target, state<=FETCH.
    - Otherwise: pc<=target, misaligned<=1, state<=HALT.
  - Priority 2, decode_ready=1: instr_valid<=0, instruction<=NOP_INSTR, state<=FETCH.
  - Otherwise hold.
  - branch_taken and decode_ready together: the branch wins; the fall-through pc+4 is discarded.
- branch_taken is ignored outside VALID.
- HALT:
  - imem_req=0, instr_valid=0, misaligned=1.
  - Leave only via reset.
- Throughput: at most one instruction per 2 cycles (FETCH then VALID); no prefetch.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- When defined:
  - Adds output fetch_timeout (1 bit, sticky, cleared by reset).
  - Adds a counter that increments each FETCH cycle without ack and resets on leaving FETCH.
  - When the count reaches TIMEOUT_CYCLES-1 with no ack: fetch_timeout<=1, imem_req drops for one cycle (state IDLE), then pc is re-fetched.
  - An ack in the cycle the limit is reached is accepted normally; no timeout is flagged.
- When undefined: no counter and no port; FETCH waits indefinitely.

Test Plan:
- Reset, then imem_ack=1 on the first req with rdata=32'h55500083 -> imem_addr=0, then instruction=32'h55500083, pc_out=0, instr_valid=1; after decode_ready, the next imem_addr=4.
- Ack delayed 3 cycles with decode_ready held low for 5 cycles -> imem_addr stays 4 during wait, instruction stays stable, no new req until decode_ready.
- Branch from pc_out=8 with branch_offset=12'hFFE -> target 8-4=4; the next fetch addr is 4 and instr_valid drops for the redirect.
- Branch from pc_out=8 with branch_offset=12'h07F -> target 8+254=32'h106, misaligned=1, state HALT, imem_req stays 0 until reset.
- branch_taken and decode_ready together at pc_out=0 with branch_offset=12'h008 -> the next fetch addr is 16, not 4.
- Reset asserted while imem_req=1, ack arrives the cycle after reset -> ack ignored, instruction=32'h00000013, then a fetch from RESET_PC. With FETCH_TIMEOUT_EN: no ack for 16 cycles -> fetch_timeout=1 and the same address is re-requested.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches one word at a time over a req/ack handshake,
// and takes branch redirects. Optional fetch watchdog under `FETCH_TIMEOUT_EN.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
`ifdef FETCH_TIMEOUT_EN
  ,parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [31:0] pc_out,
   output logic        instr_valid,
   input  logic        decode_ready,
   input  logic        branch_taken,
   input  logic [11:0] branch_offset,
   output logic        misaligned
`ifdef FETCH_TIMEOUT_EN
  ,output logic        fetch_timeout
`endif
);

   typedef enum logic [1:0] {IDLE, FETCH, VALID, HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        mis_q, mis_d;
   logic [31:0] target;

`ifdef FETCH_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          to_q, to_d;
`endif

   // Offset counts halfwords, so the byte displacement is offset*2.
   assign target = pc_out_q + {{19{branch_offset[11]}}, branch_offset, 1'b0};

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      mis_d    = mis_q;
`ifdef FETCH_TIMEOUT_EN
      cnt_d    = '0;
      to_d     = to_q;
`endif
      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            if (imem_ack) begin
               instr_d  = imem_rdata;
               pc_out_d = pc_q;
               pc_d     = pc_q + 32'd4;
               state_d  = VALID;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (cnt_q == CNT_LIM) begin
               to_d    = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         VALID: begin
            if (branch_taken) begin
               instr_d = NOP_INSTR;
               pc_d    = target;
               if (target[1:0] != 2'b00) begin
                  mis_d   = 1'b1;
                  state_d = HALT;
               end else begin
                  state_d = FETCH;
               end
            end else if (decode_ready) begin
               instr_d = NOP_INSTR;
               state_d = FETCH;
            end
         end
         HALT: state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         instr_q  <= NOP_INSTR;
         pc_out_q <= RESET_PC;
         mis_q    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         cnt_q    <= '0;
         to_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
         mis_q    <= mis_d;
`ifdef FETCH_TIMEOUT_EN
         cnt_q    <= cnt_d;
         to_q     <= to_d;
`endif
      end
   end

   // All outputs are decoded from registers; ack never reaches req combinationally.
   assign imem_req    = (state_q == FETCH);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == VALID);
   assign instruction = instr_q;
   assign pc_out      = pc_out_q;
   assign misaligned  = mis_q;
`ifdef FETCH_TIMEOUT_EN
   assign fetch_timeout = to_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized self-checking bench for instruction_fetch; expected fetch addresses
// come from a small arithmetic model of PC progression and branch targets.
module tb_instruction_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instruction;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic        decode_ready = 1'b0;
   logic        branch_taken = 1'b0;
   logic [11:0] branch_offset = '0;
   logic        misaligned;
`ifdef FETCH_TIMEOUT_EN
   logic        fetch_timeout;
`endif

   int n_chk = 0;
   int n_pass = 0;
   logic [31:0] exp_addr;

   instruction_fetch dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
      .pc_out(pc_out), .instr_valid(instr_valid), .decode_ready(decode_ready),
      .branch_taken(branch_taken), .branch_offset(branch_offset),
      .misaligned(misaligned)
`ifdef FETCH_TIMEOUT_EN
     ,.fetch_timeout(fetch_timeout)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Reference: redirect target is pc + offset halfwords, modulo 2^32.
   function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [11:0] off);
      int s;
      s = int'($signed(off)) * 2;
      return pc + 32'(s);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1; imem_ack = 1'b0; decode_ready = 1'b0; branch_taken = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   // Waits for a request at addr, delays the ack, returns word w; branch_taken
   // is toggled randomly meanwhile since it must be ignored outside VALID.
   task automatic fetch_word(input int delay, input logic [31:0] w, input logic [31:0] addr);
      int k = 0;
      while (imem_req !== 1'b1 && k < 20) begin
         branch_taken = 1'($urandom_range(0, 1)); branch_offset = 12'($urandom);
         tick(); k++;
      end
      n_chk++;
      if (imem_req !== 1'b1 || imem_addr !== addr)
         $display("FAIL fetch_req: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, addr);
      else n_pass++;
      for (int i = 0; i < delay; i++) begin
         branch_taken = 1'($urandom_range(0, 1)); branch_offset = 12'($urandom);
         tick();
         n_chk++;
         if ({imem_req, imem_addr, instr_valid} !== {1'b1, addr, 1'b0})
            $display("FAIL fetch_wait: req=%b addr=%h valid=%b, expected 1/%h/0", imem_req, imem_addr, instr_valid, addr);
         else n_pass++;
      end
      imem_ack = 1'b1; imem_rdata = w;
      tick();
      imem_ack = 1'b0; imem_rdata = $urandom; branch_taken = 1'b0;
      n_chk++;
      if ({instr_valid, imem_req, instruction, pc_out} !== {1'b1, 1'b0, w, addr})
         $display("FAIL fetch_latch: valid=%b req=%b instr=%h pc_out=%h, expected 1/0/%h/%h",
                  instr_valid, imem_req, instruction, pc_out, w, addr);
      else n_pass++;
   endtask

   task automatic consume(input logic [31:0] next_addr);
      decode_ready = 1'b1;
      tick();
      decode_ready = 1'b0;
      n_chk++;
      if ({instr_valid, instruction, imem_req, imem_addr} !== {1'b0, NOP, 1'b1, next_addr})
         $display("FAIL consume: valid=%b instr=%h req=%b addr=%h, expected 0/%h/1/%h",
                  instr_valid, instruction, imem_req, imem_addr, NOP, next_addr);
      else n_pass++;
   endtask

   task automatic redirect(input logic [11:0] off, input logic rdy, input logic [31:0] tgt);
      branch_taken = 1'b1; decode_ready = rdy; branch_offset = off;
      tick();
      branch_taken = 1'b0; decode_ready = 1'b0;
      n_chk++;
      if ({instr_valid, instruction, imem_req, imem_addr, misaligned} !== {1'b0, NOP, 1'b1, tgt, 1'b0})
         $display("FAIL redirect: valid=%b instr=%h req=%b addr=%h mis=%b, expected 0/%h/1/%h/0",
                  instr_valid, instruction, imem_req, imem_addr, misaligned, NOP, tgt);
      else n_pass++;
   endtask

   task automatic test_reset();
      apply_reset();
      reset = 1'b1;
      tick();
      n_chk++;
      if ({imem_req, instr_valid, misaligned, instruction, pc_out, imem_addr} !==
          {1'b0, 1'b0, 1'b0, NOP, 32'h0, 32'h0})
         $display("FAIL reset_state: req=%b valid=%b mis=%b instr=%h pc_out=%h addr=%h",
                  imem_req, instr_valid, misaligned, instruction, pc_out, imem_addr);
      else n_pass++;
`ifdef FETCH_TIMEOUT_EN
      n_chk++;
      if (fetch_timeout !== 1'b0) $display("FAIL reset_timeout: got %b, expected 0", fetch_timeout);
      else n_pass++;
`endif
      reset = 1'b0;
   endtask

   task automatic test_first_fetch();
      fetch_word(0, 32'h5550_0083, 32'h0);
      consume(32'h4);
   endtask

   task automatic test_delayed_ack();
      logic [31:0] w = $urandom;
      fetch_word(3, w, 32'h4);
      for (int i = 0; i < 5; i++) begin
         tick();
         n_chk++;
         if ({imem_req, instr_valid, instruction, pc_out} !== {1'b0, 1'b1, w, 32'h4})
            $display("FAIL hold_valid: req=%b valid=%b instr=%h pc_out=%h, expected 0/1/%h/4",
                     imem_req, instr_valid, instruction, pc_out, w);
         else n_pass++;
      end
      consume(32'h8);
   endtask

   task automatic test_branch_back();
      fetch_word(int'($urandom_range(0, 3)), $urandom, 32'h8);
      redirect(12'hFFE, 1'b0, ref_target(32'h8, 12'hFFE));
   endtask

   task automatic test_branch_and_ready();
      fetch_word(1, $urandom, 32'h4);
      redirect(12'hFFE, 1'b1, 32'h0);
      fetch_word(0, $urandom, 32'h0);
      redirect(12'h008, 1'b1, ref_target(32'h0, 12'h008));
   endtask

   task automatic test_wrap();
      fetch_word(2, $urandom, 32'd16);
      redirect(12'hFF6, 1'b0, 32'hFFFF_FFFC);
      fetch_word(0, $urandom, 32'hFFFF_FFFC);
      consume(32'h0);
      exp_addr = 32'h0;
   endtask

   task automatic test_random();
      for (int it = 0; it < 12; it++) begin
         logic [31:0] w = $urandom;
         logic [11:0] off;
         int hold = int'($urandom_range(0, 3));
         fetch_word(int'($urandom_range(0, 4)), w, exp_addr);
         for (int i = 0; i < hold; i++) begin
            tick();
            n_chk++;
            if ({imem_req, instr_valid, instruction} !== {1'b0, 1'b1, w})
               $display("FAIL rand_hold: req=%b valid=%b instr=%h, expected 0/1/%h", imem_req, instr_valid, instruction, w);
            else n_pass++;
         end
         if ($urandom_range(0, 1) == 1) begin
            off = 12'($urandom) & 12'hFFE;
            exp_addr = ref_target(exp_addr, off);
            redirect(off, 1'($urandom_range(0, 1)), exp_addr);
         end else begin
            exp_addr = exp_addr + 32'd4;
            consume(exp_addr);
         end
      end
   endtask

   task automatic test_misaligned();
      apply_reset();
      fetch_word(0, $urandom, 32'h0); consume(32'h4);
      fetch_word(1, $urandom, 32'h4); consume(32'h8);
      fetch_word(0, $urandom, 32'h8);
      branch_taken = 1'b1; branch_offset = 12'h07F;
      tick();
      branch_taken = 1'b0;
      n_chk++;
      if ({misaligned, imem_req, instr_valid, instruction} !== {1'b1, 1'b0, 1'b0, NOP})
         $display("FAIL misalign_enter: mis=%b req=%b valid=%b instr=%h, expected 1/0/0/%h",
                  misaligned, imem_req, instr_valid, instruction, NOP);
      else n_pass++;
      for (int i = 0; i < 20; i++) begin
         imem_ack = 1'($urandom_range(0, 1)); decode_ready = 1'($urandom_range(0, 1));
         branch_taken = 1'($urandom_range(0, 1)); branch_offset = 12'($urandom);
         tick();
         n_chk++;
         if ({misaligned, imem_req, instr_valid} !== 3'b100)
            $display("FAIL halt_hold: mis=%b req=%b valid=%b, expected 1/0/0", misaligned, imem_req, instr_valid);
         else n_pass++;
      end
      apply_reset();
      n_chk++;
      if (misaligned !== 1'b0) $display("FAIL halt_reset: mis=%b, expected 0", misaligned);
      else n_pass++;
   endtask

   task automatic test_reset_mid_fetch();
      logic [31:0] w = $urandom;
      fetch_word(0, w, 32'h0); consume(32'h4);
      reset = 1'b1;
      tick();
      reset = 1'b0; imem_ack = 1'b1; imem_rdata = $urandom;
      tick();
      imem_ack = 1'b0;
      n_chk++;
      if ({instruction, instr_valid, imem_req, imem_addr} !== {NOP, 1'b0, 1'b1, 32'h0})
         $display("FAIL stale_ack: instr=%h valid=%b req=%b addr=%h, expected %h/0/1/0",
                  instruction, instr_valid, imem_req, imem_addr, NOP);
      else n_pass++;
      fetch_word(2, w, 32'h0);
   endtask

`ifdef FETCH_TIMEOUT_EN
   task automatic test_timeout();
      apply_reset();
      tick();
      for (int i = 0; i < 15; i++) tick();
      imem_ack = 1'b1; imem_rdata = 32'hA5A5_0013;
      tick();
      imem_ack = 1'b0;
      n_chk++;
      if ({instr_valid, fetch_timeout, instruction} !== {1'b1, 1'b0, 32'hA5A5_0013})
         $display("FAIL ack_at_limit: valid=%b to=%b instr=%h, expected 1/0/a5a50013",
                  instr_valid, fetch_timeout, instruction);
      else n_pass++;
      consume(32'h4);
      for (int i = 0; i < 15; i++) tick();
      n_chk++;
      if ({imem_req, fetch_timeout} !== 2'b10)
         $display("FAIL pre_timeout: req=%b to=%b, expected 1/0", imem_req, fetch_timeout);
      else n_pass++;
      tick();
      n_chk++;
      if ({imem_req, fetch_timeout} !== 2'b01)
         $display("FAIL timeout_flag: req=%b to=%b, expected 0/1", imem_req, fetch_timeout);
      else n_pass++;
      tick();
      n_chk++;
      if ({imem_req, imem_addr, fetch_timeout} !== {1'b1, 32'h4, 1'b1})
         $display("FAIL refetch: req=%b addr=%h to=%b, expected 1/4/1", imem_req, imem_addr, fetch_timeout);
      else n_pass++;
      fetch_word(0, $urandom, 32'h4);
   endtask
`endif

   initial begin
      test_reset();
      test_first_fetch();
      test_delayed_ack();
      test_branch_back();
      test_branch_and_ready();
      test_wrap();
      test_random();
      test_misaligned();
      test_reset_mid_fetch();
`ifdef FETCH_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
